// File: rtl/inst_sequencer.sv
// Instruction register and T-cycle counter for the 6502 core.
// Arbitrates reset/NMI/IRQ at instruction boundaries and supplies the vector.
module inst_sequencer #(
    parameter int CYCW = 3,
    parameter int NIRQ = 1,
    parameter int SRCW = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rdy,
    input  logic [7:0]       data_in,
    input  logic             icyc,
    input  logic             rcyc,
    input  logic [NIRQ-1:0]  irq,
    input  logic             nmi,
    input  logic             i_flag,
    output logic [7:0]       inst,
    output logic [CYCW-1:0]  cycle,
    output logic [1:0]       int_type,
    output logic [SRCW-1:0]  int_src,
    output logic [15:0]      vector,
    output logic             nmi_pend,
    output logic             cyc_ovf
);

    localparam logic [CYCW-1:0] MAXCYC = '1;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_RST  = 2'b01;
    localparam logic [1:0] T_NMI  = 2'b10;
    localparam logic [1:0] T_IRQ  = 2'b11;

    logic            nmi_q;
    logic            nmi_edge;
    logic            take_nmi;
    logic            take_irq;
    logic [SRCW-1:0] irq_idx;

    // Lowest-index pending IRQ line wins.
    always_comb begin
        irq_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                irq_idx = SRCW'(i);
            end
        end
    end

    assign nmi_edge = nmi & ~nmi_q;
    assign take_nmi = nmi_pend | nmi_edge;
    assign take_irq = (|irq) & ~i_flag;

    // Sequencer state: NMI edge detector runs regardless of rdy.
    always_ff @(posedge clk) begin
        if (!clr) begin
            inst     <= 8'h00;
            cycle    <= '0;
            int_type <= T_RST;
            int_src  <= '0;
            vector   <= 16'hFFFC;
            nmi_pend <= 1'b0;
            cyc_ovf  <= 1'b0;
            nmi_q    <= 1'b0;
        end else begin
            nmi_q <= nmi;
            if (rdy && rcyc) begin
                cycle <= '0;
                if (take_nmi) begin
                    inst     <= 8'h00;
                    int_type <= T_NMI;
                    int_src  <= '0;
                    vector   <= 16'hFFFA;
                    nmi_pend <= 1'b0;
                end else if (take_irq) begin
                    inst     <= 8'h00;
                    int_type <= T_IRQ;
                    int_src  <= irq_idx;
                    vector   <= 16'hFFFE;
                end else begin
                    inst     <= data_in;
                    int_type <= T_NONE;
                    int_src  <= '0;
                    vector   <= 16'hFFFE;
                end
            end else begin
                if (nmi_edge) begin
                    nmi_pend <= 1'b1;
                end
                if (rdy && icyc) begin
                    if (cycle == MAXCYC) begin
                        cyc_ovf <= 1'b1;
                    end else begin
                        cycle <= cycle + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Owns the instruction register and the T-cycle counter that feed the opcode/cycle decoder of the 6502 core.
- Replaces the free-standing cycle counter. Arbitrates reset, NMI and NIRQ maskable interrupt lines at each instruction boundary, forcing opcode 8'h00 when an interrupt is taken.
- Supplies the interrupt kind, the winning IRQ source and the 16-bit vector address to the datapath.
- Generalises the fixed 3-bit cycle and single-IRQ scheme: counter width and IRQ channel count are parameters, and the block adds NMI edge detection, RDY stall and cycle-overflow detection.

Parameters:
- CYCW, 3, cycle counter width; MAXCYC = 2**CYCW-1.
- NIRQ, 1, number of level-sensitive IRQ inputs (1..8).
- SRCW, 3, width of int_src; must satisfy 2**SRCW >= NIRQ.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-low.
- rdy  in  1  1 = advance; 0 = hold all state except NMI edge detector.
- data_in  in  8  data bus; opcode sampled on restart.
- icyc  in  1  from decoder: advance to next cycle.
- rcyc  in  1  from decoder: last cycle, load next instruction.
- irq  in  NIRQ  level IRQ requests, bit 0 highest priority.
- nmi  in  1  non-maskable request, rising-edge sensitive.
- i_flag  in  1  status I bit; 1 masks all irq.
- inst  out  8  current opcode to decoder.
- cycle  out  CYCW  current T-cycle to decoder.
- int_type  out  2  00 none/BRK, 01 reset, 10 nmi, 11 irq.
- int_src  out  SRCW  index of accepted irq line (valid when int_type=11, else 0).
- vector  out  16  vector address for current instruction.
- nmi_pend  out  1  latched NMI edge not yet accepted.
- cyc_ovf  out  1  sticky: icyc seen with cycle==MAXCYC.

Behaviour:
- Reset (clr=0 at clock edge): cycle=0, inst=8'h00, int_type=01, int_src=0, vector=16'hFFFC, nmi_pend=0, cyc_ovf=0, nmi_q=0. Reset dominates rdy, icyc, rcyc. Reset mid-instruction abandons it. The first instruction after release is therefore the reset interrupt sequence.
- NMI detector (runs even when rdy=0): nmi_q<=nmi. An edge (nmi & ~nmi_q) sets nmi_pend. nmi_pend is cleared only on acceptance.
- When rdy=0: inst, cycle, int_type, int_src, vector and cyc_ovf hold; icyc/rcyc are ignored.
- When rdy=1, rcyc=1 (restart; rcyc wins over icyc): cycle<=0, and the next instruction is chosen by priority:
  1. NMI when nmi_pend or a same-cycle edge: inst<=00, int_type<=10, vector<=FFFA, nmi_pend<=0. A same-cycle edge is consumed and does not leave nmi_pend set.
  2. IRQ when (|irq) & ~i_flag: inst<=00, int_type<=11, int_src<=lowest set index, vector<=FFFE.
  3. Otherwise: inst<=data_in, int_type<=00, int_src<=0, vector<=FFFE (software BRK uses the IRQ vector).
- When rdy=1, icyc=1, rcyc=0:
  - If cycle<MAXCYC: cycle<=cycle+1.
  - If cycle==MAXCYC: cycle holds (saturates, no wrap) and cyc_ovf<=1. cyc_ovf stays set until reset.
- When rdy=1 and neither icyc nor rcyc is asserted: all state holds.
- An NMI edge arriving during an IRQ or NMI sequence is latched and taken at the next rcyc; it is never lost.
- IRQ is level-sampled only at rcyc. An IRQ deasserted before rcyc is not taken.
- All outputs are registered; decode sees a new inst/cycle one clock after rcyc/icyc.
- Combinational paths are only the priority encoder and the next-state logic. No latches; every output is assigned in every branch.

Test Plan:
- Reset release: clr=0 for 2 clocks with icyc=1, nmi=1 -> inst=00, cycle=0, int_type=01, vector=FFFC, nmi_pend=0. After release, 7 icyc pulses then rcyc with data_in=A9 -> inst=A9, cycle=0, int_type=00.
- Fetch and count: data_in=6D, rcyc -> inst=6D. Five icyc pulses -> cycle=5. rcyc+icyc together -> cycle=0 (rcyc wins).
- Priority: NIRQ=4, irq=4'b1100, i_flag=0, nmi rising at same cycle as rcyc -> int_type=10, vector=FFFA, nmi_pend=0. Next rcyc -> int_type=11, int_src=2, vector=FFFE. Same again with i_flag=1 -> inst=data_in.
- Stall: rdy=0 with icyc=1 for 3 clocks while nmi pulses 0->1 -> cycle unchanged, nmi_pend=1. After rdy=1, next rcyc -> NMI taken.
- Overflow: CYCW=3, 8 icyc pulses from cycle=0 -> cycle=7, cyc_ovf=1. Subsequent rcyc -> cycle=0, cyc_ovf still 1. clr=0 -> cyc_ovf=0.
- BRK: data_in=00, no requests, rcyc -> inst=00, int_type=00, vector=FFFE.
